// File: rtl/adder_checker.sv
// adder_checker: re-checks every adder vector against a+b+cin,
// counts checks/failures and latches the first failing vector.
module adder_checker #(
  parameter int BIT_WIDTH = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 halt_on_error,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  input  logic [BIT_WIDTH-1:0] sum,
  input  logic                 overflow,
  output logic                 busy,
  output logic                 halted,
  output logic                 error,
  output logic                 error_pulse,
  output logic [CNT_WIDTH-1:0] chk_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [BIT_WIDTH-1:0] first_a,
  output logic [BIT_WIDTH-1:0] first_b,
  output logic                 first_cin,
  output logic                 first_ovf,
  output logic [BIT_WIDTH-1:0] first_sum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e state_q, state_d;

  logic                 v1_q, v1_d;
  logic [BIT_WIDTH-1:0] a1_q, a1_d;
  logic [BIT_WIDTH-1:0] b1_q, b1_d;
  logic                 cin1_q, cin1_d;
  logic [BIT_WIDTH-1:0] sum1_q, sum1_d;
  logic                 ovf1_q, ovf1_d;

  logic                 error_q, error_d;
  logic                 pulse_q, pulse_d;
  logic [CNT_WIDTH-1:0] chk_q, chk_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;

  logic [BIT_WIDTH-1:0] fa_q, fa_d;
  logic [BIT_WIDTH-1:0] fb_q, fb_d;
  logic                 fcin_q, fcin_d;
  logic                 fovf_q, fovf_d;
  logic [BIT_WIDTH-1:0] fsum_q, fsum_d;

  logic [BIT_WIDTH:0]   expected;
  logic [BIT_WIDTH:0]   observed;
  logic                 mismatch;
  logic                 halt_now;
  logic                 capture;

  // Reference sum of the staged vector and mismatch/halt decision
  always_comb begin
    expected = {1'b0, a1_q}
             + {1'b0, b1_q}
             + {{BIT_WIDTH{1'b0}}, cin1_q};
    observed = {ovf1_q, sum1_q};
    mismatch = v1_q && (observed != expected);
    halt_now = (state_q == RUN)
            && mismatch
            && halt_on_error;
  end

  // Next-state logic; clear returns to IDLE from any state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (halt_now)     state_d = HALT;
        else if (!enable) state_d = IDLE;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clear) state_d = IDLE;
  end

  // Stage 1: sample the vector in RUN unless halting this edge
  always_comb begin
    capture = (state_q == RUN)
           && in_valid
           && !halt_now
           && !clear;
    v1_d    = capture;
    a1_d    = a1_q;
    b1_d    = b1_q;
    cin1_d  = cin1_q;
    sum1_d  = sum1_q;
    ovf1_d  = ovf1_q;
    if (capture) begin
      a1_d   = a;
      b1_d   = b;
      cin1_d = carry_in;
      sum1_d = sum;
      ovf1_d = overflow;
    end
    if (clear) begin
      a1_d   = '0;
      b1_d   = '0;
      cin1_d = 1'b0;
      sum1_d = '0;
      ovf1_d = 1'b0;
    end
  end

  // Stage 2: saturating counters, flags and first-failure capture
  always_comb begin
    chk_d   = chk_q;
    err_d   = err_q;
    error_d = error_q;
    pulse_d = 1'b0;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fcin_d  = fcin_q;
    fovf_d  = fovf_q;
    fsum_d  = fsum_q;
    if (v1_q && chk_q != CNT_MAX) begin
      chk_d = chk_q + CNT_ONE;
    end
    if (mismatch) begin
      pulse_d = 1'b1;
      error_d = 1'b1;
      if (err_q != CNT_MAX) err_d = err_q + CNT_ONE;
      if (!error_q) begin
        fa_d   = a1_q;
        fb_d   = b1_q;
        fcin_d = cin1_q;
        fovf_d = ovf1_q;
        fsum_d = sum1_q;
      end
    end
    if (clear) begin
      chk_d   = '0;
      err_d   = '0;
      error_d = 1'b0;
      pulse_d = 1'b0;
      fa_d    = '0;
      fb_d    = '0;
      fcin_d  = 1'b0;
      fovf_d  = 1'b0;
      fsum_d  = '0;
    end
  end

  // All state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      cin1_q  <= 1'b0;
      sum1_q  <= '0;
      ovf1_q  <= 1'b0;
      error_q <= 1'b0;
      pulse_q <= 1'b0;
      chk_q   <= '0;
      err_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      fcin_q  <= 1'b0;
      fovf_q  <= 1'b0;
      fsum_q  <= '0;
    end else begin
      state_q <= state_d;
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      cin1_q  <= cin1_d;
      sum1_q  <= sum1_d;
      ovf1_q  <= ovf1_d;
      error_q <= error_d;
      pulse_q <= pulse_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fcin_q  <= fcin_d;
      fovf_q  <= fovf_d;
      fsum_q  <= fsum_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign halted      = (state_q == HALT);
  assign error       = error_q;
  assign error_pulse = pulse_q;
  assign chk_count   = chk_q;
  assign err_count   = err_q;
  assign first_a     = fa_q;
  assign first_b     = fb_q;
  assign first_cin   = fcin_q;
  assign first_ovf   = fovf_q;
  assign first_sum   = fsum_q;

endmodule

// File: tb/tb_adder_checker.sv
// tb_adder_checker: scoreboard bench with a behavioural model
// of the checker, directed test-plan cases and random traffic.
module tb_adder_checker;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       halt_on_error = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       carry_in = 1'b0;
  logic [7:0] sum = '0;
  logic       overflow = 1'b0;
  logic       busy, halted, error, error_pulse;
  logic [7:0] chk_count, err_count;
  logic [7:0] first_a, first_b, first_sum;
  logic       first_cin, first_ovf;

  adder_checker #(.BIT_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable), .clear(clear),
    .halt_on_error(halt_on_error), .in_valid(in_valid),
    .a(a), .b(b), .carry_in(carry_in), .sum(sum),
    .overflow(overflow), .busy(busy), .halted(halted),
    .error(error), .error_pulse(error_pulse),
    .chk_count(chk_count), .err_count(err_count),
    .first_a(first_a), .first_b(first_b),
    .first_cin(first_cin), .first_ovf(first_ovf),
    .first_sum(first_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a; int b; int cin; int sum; int ovf;
  } vec_t;

  typedef struct {
    int busy; int halted; int error; int pulse;
    int chk; int err;
    int fa; int fb; int fcin; int fovf; int fsum;
  } exp_t;

  exp_t sbq[$];
  vec_t pend[$];

  int checks = 0;
  int errors = 0;

  // model state
  bit   m_running = 0;
  bit   m_halted = 0;
  bit   m_err = 0;
  bit   m_pulse = 0;
  int   m_chk = 0;
  int   m_errc = 0;
  vec_t m_first = '{0, 0, 0, 0, 0};

  function automatic int sat(input int x);
    return (x < 255) ? x + 1 : 255;
  endfunction

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_running = 0;
    m_halted  = 0;
    m_err     = 0;
    m_pulse   = 0;
    m_chk     = 0;
    m_errc    = 0;
    m_first   = '{0, 0, 0, 0, 0};
    pend.delete();
  endtask

  // Apply one cycle of inputs and predict the outputs after the edge
  task automatic cyc(input bit rn, input bit cl, input bit en,
                     input bit hoe, input bit iv, input vec_t v);
    exp_t e;
    bit   stop;
    vec_t s;
    @(negedge clk);
    n_rst = rn; clear = cl; enable = en; halt_on_error = hoe;
    in_valid = iv; a = 8'(v.a); b = 8'(v.b); carry_in = v.cin[0];
    sum = 8'(v.sum); overflow = v.ovf[0];
    if (!rn || cl) begin
      model_reset();
    end else begin
      stop = 0;
      m_pulse = 0;
      if (pend.size() > 0) begin
        s = pend.pop_front();
        m_chk = sat(m_chk);
        if (s.ovf * 256 + s.sum != s.a + s.b + s.cin) begin
          m_errc = sat(m_errc);
          m_pulse = 1;
          if (!m_err) m_first = s;
          m_err = 1;
          if (m_running && hoe) stop = 1;
        end
      end
      if (m_running && iv && !stop) pend.push_back(v);
      if (stop) begin
        m_running = 0;
        m_halted = 1;
      end else if (!m_halted) begin
        m_running = en;
      end
    end
    e.busy = m_running; e.halted = m_halted;
    e.error = m_err; e.pulse = m_pulse;
    e.chk = m_chk; e.err = m_errc;
    e.fa = m_first.a; e.fb = m_first.b; e.fcin = m_first.cin;
    e.fovf = m_first.ovf; e.fsum = m_first.sum;
    sbq.push_back(e);
  endtask

  // Monitor: one expected snapshot per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("busy", busy, e.busy);
        chk("halted", halted, e.halted);
        chk("error", error, e.error);
        chk("error_pulse", error_pulse, e.pulse);
        chk("chk_count", chk_count, e.chk);
        chk("err_count", err_count, e.err);
        chk("first_a", first_a, e.fa);
        chk("first_b", first_b, e.fb);
        chk("first_cin", first_cin, e.fcin);
        chk("first_ovf", first_ovf, e.fovf);
        chk("first_sum", first_sum, e.fsum);
      end
    end
  end

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  function automatic vec_t mk(input int av, input int bv, input int cv,
                              input int sv, input int ov);
    vec_t v;
    v.a = av; v.b = bv; v.cin = cv; v.sum = sv; v.ovf = ov;
    return v;
  endfunction

  function automatic vec_t rnd_vec(input bit bad);
    vec_t v;
    int   t;
    v.a = int'($urandom_range(0, 255));
    v.b = int'($urandom_range(0, 255));
    v.cin = int'($urandom_range(0, 1));
    t = v.a + v.b + v.cin;
    if (bad) t = t ^ (1 << $urandom_range(0, 8));
    v.sum = t & 255;
    v.ovf = (t >> 8) & 1;
    return v;
  endfunction

  vec_t z;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    z = mk(0, 0, 0, 0, 0);
    // reset
    cyc(0, 0, 0, 0, 0, z);
    cyc(0, 0, 0, 0, 0, z);
    settle();
    chk("rst_chk", chk_count, 0);
    chk("rst_busy", busy, 0);

    // correct vectors
    cyc(1, 0, 1, 0, 0, z);
    cyc(1, 0, 1, 0, 1, mk(8'h7F, 8'h01, 0, 8'h80, 0));
    cyc(1, 0, 1, 0, 1, mk(8'hFF, 8'h01, 1, 8'h01, 1));
    cyc(1, 0, 1, 0, 0, z);
    settle();
    chk("good_chk", chk_count, 2);
    chk("good_err", err_count, 0);
    chk("good_error", error, 0);

    // single fault, then a second fault
    cyc(1, 0, 1, 0, 1, mk(8'h0F, 8'h01, 0, 8'h11, 0));
    cyc(1, 0, 1, 0, 0, z);
    settle();
    chk("f1_pulse", error_pulse, 1);
    chk("f1_err", err_count, 1);
    chk("f1_sum", first_sum, 8'h11);
    cyc(1, 0, 1, 0, 0, z);
    settle();
    chk("f1_pulse_off", error_pulse, 0);
    cyc(1, 0, 1, 0, 1, mk(8'h20, 8'h20, 1, 8'h40, 0));
    cyc(1, 0, 1, 0, 0, z);
    settle();
    chk("f2_err", err_count, 2);
    chk("f2_first_a", first_a, 8'h0F);

    // halt mode
    cyc(1, 1, 0, 1, 0, z);
    cyc(1, 0, 1, 1, 0, z);
    cyc(1, 0, 1, 1, 1, mk(8'h10, 8'h10, 0, 8'h21, 0));
    cyc(1, 0, 1, 1, 1, mk(8'h10, 8'h10, 0, 8'h20, 0));
    for (int i = 0; i < 6; i++)
      cyc(1, 0, i[0], i[1], 1, rnd_vec(i[2]));
    settle();
    chk("halt_halted", halted, 1);
    chk("halt_chk", chk_count, 1);
    chk("halt_err", err_count, 1);
    cyc(1, 1, 1, 1, 1, rnd_vec(1));
    settle();
    chk("halt_clr_halted", halted, 0);
    chk("halt_clr_chk", chk_count, 0);
    chk("halt_clr_error", error, 0);

    // saturation
    cyc(1, 1, 0, 0, 0, z);
    cyc(1, 0, 1, 0, 0, z);
    for (int i = 0; i < 300; i++) cyc(1, 0, 1, 0, 1, rnd_vec(1));
    cyc(1, 0, 1, 0, 0, z);
    settle();
    chk("sat_err", err_count, 255);
    chk("sat_chk", chk_count, 255);
    chk("sat_pulse", error_pulse, 1);

    // gating and drain
    cyc(1, 1, 0, 0, 0, z);
    cyc(1, 0, 0, 0, 1, rnd_vec(0));
    cyc(1, 0, 0, 0, 1, rnd_vec(1));
    settle();
    chk("gate_chk", chk_count, 0);
    cyc(1, 0, 1, 0, 0, z);
    cyc(1, 0, 1, 0, 1, rnd_vec(0));
    cyc(1, 0, 0, 0, 0, z);
    settle();
    chk("drain_chk", chk_count, 1);
    chk("drain_busy", busy, 0);

    // reset mid-run
    cyc(1, 0, 1, 0, 0, z);
    cyc(1, 0, 1, 0, 1, rnd_vec(1));
    cyc(0, 0, 1, 0, 0, z);
    settle();
    chk("mrst_chk", chk_count, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_pulse", error_pulse, 0);
    cyc(1, 0, 0, 0, 0, z);
    settle();
    chk("mrst_pulse2", error_pulse, 0);
    chk("mrst_error", error, 0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 99) != 0,
          $urandom_range(0, 79) == 0,
          $urandom_range(0, 9) < 8,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) < 7,
          rnd_vec($urandom_range(0, 4) == 0));
    end
    settle();
    chk("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
